// File: rtl/freelist_if.sv
// Dispatch/retire handshake bundle for the physical-register free list.
// Dispatch and retire drive requests; the free list returns tags, grants and status.
interface freelist_if #(
  parameter int WAYS  = 3,
  parameter int PR_W  = 6,
  parameter int CNT_W = 6
);
  logic [WAYS-1:0]           dispatch_req;
  logic [WAYS-1:0]           retire_free_valid;
  logic [WAYS-1:0][PR_W-1:0] retire_told_idx;
  logic                      squash;
  logic [WAYS-1:0][PR_W-1:0] free_t_idx;
  logic [WAYS-1:0]           free_valid;
  logic [CNT_W-1:0]          free_count;
  logic                      overflow_err;

  modport master (
    output dispatch_req, retire_free_valid, retire_told_idx, squash,
    input  free_t_idx, free_valid, free_count, overflow_err
  );

  modport slave (
    input  dispatch_req, retire_free_valid, retire_told_idx, squash,
    output free_t_idx, free_valid, free_count, overflow_err
  );
endinterface

// File: rtl/freelist.sv
// Circular free list of physical-register tags: in-order multi-way allocation at head,
// multi-way release at tail, and single-cycle squash recovery by snapping head to tail.

module freelist_lane #(
  parameter int FL_SIZE = 32,
  parameter int PTR_W   = 5,
  parameter int CNT_W   = 6
) (
  input  logic             req,
  input  logic             rfv,
  input  logic             squash,
  input  logic [CNT_W-1:0] n_pre,
  input  logic [CNT_W-1:0] m_pre,
  input  logic [CNT_W-1:0] count,
  input  logic [CNT_W-1:0] room,
  input  logic [PTR_W-1:0] head,
  input  logic [PTR_W-1:0] tail,
  output logic             grant,
  output logic             wr_en,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W-1:0] wr_ptr
);
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p,
                                                input logic [CNT_W-1:0] off);
    logic [CNT_W:0] s;
    s = {1'b0, off} + (CNT_W+1)'(p);
    if (s >= (CNT_W+1)'(FL_SIZE)) s = s - (CNT_W+1)'(FL_SIZE);
    return PTR_W'(s);
  endfunction

  // n_pre < count is n_pre+1 <= count without the extra carry bit
  assign grant  = req & (n_pre < count) & ~squash;
  assign wr_en  = rfv & (m_pre < room);
  assign rd_ptr = wrap_add(head, n_pre);
  assign wr_ptr = wrap_add(tail, m_pre);
endmodule

module freelist #(
  parameter int SUPERSCALAR_WAYS = 3,
  parameter int PHYS_REGS        = 64,
  parameter int ARCH_REGS        = 32
) (
  input logic       clock,
  input logic       reset,
  freelist_if.slave fl
);
  localparam int PR_W    = $clog2(PHYS_REGS);
  localparam int FL_SIZE = PHYS_REGS - ARCH_REGS;
  localparam int PTR_W   = $clog2(FL_SIZE);
  localparam int CNT_W   = PTR_W + 1;
  localparam int WAYS    = SUPERSCALAR_WAYS;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p,
                                                input logic [CNT_W-1:0] off);
    logic [CNT_W:0] s;
    s = {1'b0, off} + (CNT_W+1)'(p);
    if (s >= (CNT_W+1)'(FL_SIZE)) s = s - (CNT_W+1)'(FL_SIZE);
    return PTR_W'(s);
  endfunction

  logic [FL_SIZE-1:0][PR_W-1:0] fl_buf;
  logic [PTR_W-1:0]             head, tail;
  logic [CNT_W-1:0]             count;
  logic                         ovf_q;

  logic [WAYS-1:0][CNT_W-1:0]   n_pre, m_pre;
  logic [WAYS-1:0][PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [WAYS-1:0]              grant, wr_en;
  logic [CNT_W-1:0]             n_alloc, n_free, n_wr, avail, room, count_next;
  logic [PTR_W-1:0]             head_next, tail_next;
  logic                         overflow;

  for (genvar i = 0; i < WAYS; i++) begin : g_lane
    if (i == 0) begin : g_first
      assign n_pre[i] = '0;
      assign m_pre[i] = '0;
    end else begin : g_rest
      assign n_pre[i] = n_pre[i-1] + CNT_W'(fl.dispatch_req[i-1]);
      assign m_pre[i] = m_pre[i-1] + CNT_W'(fl.retire_free_valid[i-1]);
    end

    freelist_lane #(.FL_SIZE(FL_SIZE), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_lane (
      .req    (fl.dispatch_req[i]),
      .rfv    (fl.retire_free_valid[i]),
      .squash (fl.squash),
      .n_pre  (n_pre[i]),
      .m_pre  (m_pre[i]),
      .count  (count),
      .room   (room),
      .head   (head),
      .tail   (tail),
      .grant  (grant[i]),
      .wr_en  (wr_en[i]),
      .rd_ptr (rd_ptr[i]),
      .wr_ptr (wr_ptr[i])
    );

    assign fl.free_t_idx[i] = fl_buf[rd_ptr[i]];
  end

  always_comb begin
    n_alloc = '0;
    n_free  = '0;
    n_wr    = '0;
    for (int i = 0; i < WAYS; i++) begin
      n_alloc = n_alloc + CNT_W'(grant[i]);
      n_free  = n_free  + CNT_W'(fl.retire_free_valid[i]);
      n_wr    = n_wr    + CNT_W'(wr_en[i]);
    end
  end

  // room = slots still holding in-flight tags once this cycle's grants leave the free window
  assign avail      = count - n_alloc;
  assign room       = CNT_W'(FL_SIZE) - avail;
  assign overflow   = n_free > room;
  assign count_next = avail + n_wr;
  assign head_next  = wrap_add(head, n_alloc);
  assign tail_next  = wrap_add(tail, n_wr);

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < FL_SIZE; i++) fl_buf[i] <= PR_W'(ARCH_REGS + i);
      head  <= '0;
      tail  <= '0;
      count <= CNT_W'(FL_SIZE);
      ovf_q <= 1'b0;
    end else begin
      for (int i = 0; i < WAYS; i++)
        if (wr_en[i]) fl_buf[wr_ptr[i]] <= fl.retire_told_idx[i];
      tail  <= tail_next;
      // squash: every slot past the new tail becomes free again, in place
      head  <= fl.squash ? tail_next : head_next;
      count <= fl.squash ? CNT_W'(FL_SIZE) : count_next;
      ovf_q <= overflow;
    end
  end

  assign fl.free_valid   = grant;
  assign fl.free_count   = count;
  assign fl.overflow_err = ovf_q;
endmodule

// File: tb/tb_freelist.sv
// Scenario bench for freelist: a queue model of free and in-flight tags predicts every
// cycle's outputs; predictions and observations are queued and compared per scenario.
module tb_freelist;
  typedef struct packed {
    logic [2:0]      v;
    logic [2:0][5:0] t;
    logic [5:0]      cnt;
    logic            ovf;
  } snap_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   fq[$];
  int   iq[$];
  logic m_ovf;
  snap_t exp_q[$];
  snap_t obs_q[$];
  snap_t last;

  freelist_if #(.WAYS(3), .PR_W(6), .CNT_W(6)) fi ();

  freelist #(.SUPERSCALAR_WAYS(3), .PHYS_REGS(64), .ARCH_REGS(32)) dut (
    .clock (clock),
    .reset (reset),
    .fl    (fi)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    fq.delete();
    iq.delete();
    for (int k = 0; k < 32; k++) fq.push_back(32 + k);
    m_ovf = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    fi.dispatch_req = '0;
    fi.retire_free_valid = '0;
    fi.retire_told_idx = '0;
    fi.squash = 1'b0;
    @(posedge clock);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  // drive one cycle, record observed and predicted outputs, then advance the model
  task automatic step(input logic rst, input logic [2:0] req, input logic [2:0] rfv,
                      input logic [2:0][5:0] told, input logic sq);
    snap_t e, o;
    int pool[$];
    int n;
    logic ovf;
    reset = rst;
    fi.dispatch_req = req;
    fi.retire_free_valid = rfv;
    fi.retire_told_idx = told;
    fi.squash = sq;
    #1;
    o.v = fi.free_valid;
    o.t = fi.free_t_idx;
    o.cnt = fi.free_count;
    o.ovf = fi.overflow_err;
    pool = {fq, iq};
    n = 0;
    e.cnt = 6'(fq.size());
    e.ovf = m_ovf;
    for (int i = 0; i < 3; i++) begin
      e.t[i] = 6'(pool[n]);
      e.v[i] = req[i] && (n < fq.size()) && !sq;
      if (req[i]) n++;
    end
    exp_q.push_back(e);
    obs_q.push_back(o);
    last = o;
    @(posedge clock);
    if (!rst) model_reset();
    else begin
      for (int i = 0; i < 3; i++) if (e.v[i]) iq.push_back(fq.pop_front());
      ovf = 1'b0;
      for (int i = 0; i < 3; i++)
        if (rfv[i]) begin
          if (iq.size() > 0) begin
            void'(iq.pop_front());
            fq.push_back(int'(told[i]));
          end else ovf = 1'b1;
        end
      if (sq) begin
        fq = {iq, fq};
        iq.delete();
      end
      m_ovf = ovf;
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    snap_t e, o;
    do_reset();
    step(1, 3'b000, 3'b000, '0, 0);
    checks++;
    if (last.cnt !== 6'd32) begin errors++; $display("FAIL reset_count got %0d want 32", last.cnt); end
    step(1, 3'b111, 3'b000, '0, 0);
    checks += 2;
    if (last.t !== {6'd34, 6'd33, 6'd32}) begin errors++; $display("FAIL reset_tags got %h want 22 21 20", last.t); end
    if (last.v !== 3'b111) begin errors++; $display("FAIL reset_valid got %b want 111", last.v); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks += 4;
      if (o.v !== e.v) begin errors++; $display("FAIL reset sb_valid got %b want %b", o.v, e.v); end
      if (o.t !== e.t) begin errors++; $display("FAIL reset sb_tags got %h want %h", o.t, e.t); end
      if (o.cnt !== e.cnt) begin errors++; $display("FAIL reset sb_count got %0d want %0d", o.cnt, e.cnt); end
      if (o.ovf !== e.ovf) begin errors++; $display("FAIL reset sb_ovf got %b want %b", o.ovf, e.ovf); end
    end
  endtask

  task automatic test_sparse();
    snap_t e, o;
    do_reset();
    step(1, 3'b101, 3'b000, '0, 0);
    checks += 3;
    if (last.v !== 3'b101) begin errors++; $display("FAIL sparse_valid got %b want 101", last.v); end
    if (last.t[0] !== 6'd32) begin errors++; $display("FAIL sparse_tag0 got %0d want 32", last.t[0]); end
    if (last.t[2] !== 6'd33) begin errors++; $display("FAIL sparse_tag2 got %0d want 33", last.t[2]); end
    repeat (9) step(1, 3'b111, 3'b000, '0, 0);
    step(1, 3'b111, 3'b000, '0, 0);
    checks += 2;
    if (last.cnt !== 6'd3) begin errors++; $display("FAIL exhaust_count3 got %0d want 3", last.cnt); end
    if (last.t !== {6'd63, 6'd62, 6'd61}) begin errors++; $display("FAIL exhaust_tags got %h want 3f 3e 3d", last.t); end
    step(1, 3'b111, 3'b000, '0, 0);
    checks += 2;
    if (last.cnt !== 6'd0) begin errors++; $display("FAIL exhaust_count0 got %0d want 0", last.cnt); end
    if (last.v !== 3'b000) begin errors++; $display("FAIL exhaust_valid got %b want 000", last.v); end
    do_reset();
    repeat (10) step(1, 3'b111, 3'b000, '0, 0);
    step(1, 3'b111, 3'b000, '0, 0);
    checks++;
    if (last.v !== 3'b011) begin errors++; $display("FAIL partial_valid got %b want 011", last.v); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks += 4;
      if (o.v !== e.v) begin errors++; $display("FAIL sparse sb_valid got %b want %b", o.v, e.v); end
      if (o.t !== e.t) begin errors++; $display("FAIL sparse sb_tags got %h want %h", o.t, e.t); end
      if (o.cnt !== e.cnt) begin errors++; $display("FAIL sparse sb_count got %0d want %0d", o.cnt, e.cnt); end
      if (o.ovf !== e.ovf) begin errors++; $display("FAIL sparse sb_ovf got %b want %b", o.ovf, e.ovf); end
    end
  endtask

  task automatic test_free_empty();
    snap_t e, o;
    step(1, 3'b001, 3'b011, {6'd0, 6'd6, 6'd5}, 0);
    checks += 2;
    if (last.v !== 3'b000) begin errors++; $display("FAIL empty_valid got %b want 000", last.v); end
    if (last.cnt !== 6'd0) begin errors++; $display("FAIL empty_count got %0d want 0", last.cnt); end
    step(1, 3'b001, 3'b000, '0, 0);
    checks += 3;
    if (last.t[0] !== 6'd5) begin errors++; $display("FAIL refill_tag got %0d want 5", last.t[0]); end
    if (last.v !== 3'b001) begin errors++; $display("FAIL refill_valid got %b want 001", last.v); end
    if (last.cnt !== 6'd2) begin errors++; $display("FAIL refill_count got %0d want 2", last.cnt); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks += 4;
      if (o.v !== e.v) begin errors++; $display("FAIL empty sb_valid got %b want %b", o.v, e.v); end
      if (o.t !== e.t) begin errors++; $display("FAIL empty sb_tags got %h want %h", o.t, e.t); end
      if (o.cnt !== e.cnt) begin errors++; $display("FAIL empty sb_count got %0d want %0d", o.cnt, e.cnt); end
      if (o.ovf !== e.ovf) begin errors++; $display("FAIL empty sb_ovf got %b want %b", o.ovf, e.ovf); end
    end
  endtask

  task automatic test_wrap();
    snap_t e, o;
    logic [2:0]      rfv;
    logic [2:0][5:0] told;
    int              k;
    do_reset();
    repeat (11) step(1, 3'b111, 3'b000, '0, 0);
    for (int c = 0; c < 11; c++) begin
      rfv = '0;
      told = '0;
      for (int j = 0; j < 3; j++) begin
        k = 3 * c + j;
        if (k < 32) begin
          rfv[j] = 1'b1;
          told[j] = 6'((40 + k) % 64);
        end
      end
      step(1, 3'b000, rfv, told, 0);
    end
    for (int c = 0; c < 11; c++) begin
      step(1, 3'b111, 3'b000, '0, 0);
      for (int j = 0; j < 3; j++) begin
        k = 3 * c + j;
        if (k < 32) begin
          checks++;
          if (last.v[j] !== 1'b1 || last.t[j] !== 6'((40 + k) % 64)) begin
            errors++;
            $display("FAIL wrap_tag%0d got %b/%0d want 1/%0d", k, last.v[j], last.t[j], (40 + k) % 64);
          end
        end
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks += 4;
      if (o.v !== e.v) begin errors++; $display("FAIL wrap sb_valid got %b want %b", o.v, e.v); end
      if (o.t !== e.t) begin errors++; $display("FAIL wrap sb_tags got %h want %h", o.t, e.t); end
      if (o.cnt !== e.cnt) begin errors++; $display("FAIL wrap sb_count got %0d want %0d", o.cnt, e.cnt); end
      if (o.ovf !== e.ovf) begin errors++; $display("FAIL wrap sb_ovf got %b want %b", o.ovf, e.ovf); end
    end
  endtask

  task automatic test_squash();
    snap_t e, o;
    do_reset();
    repeat (2) step(1, 3'b111, 3'b000, '0, 0);
    step(1, 3'b111, 3'b001, {6'd0, 6'd0, 6'd3}, 1);
    checks++;
    if (last.v !== 3'b000) begin errors++; $display("FAIL squash_valid got %b want 000", last.v); end
    step(1, 3'b111, 3'b000, '0, 0);
    checks += 2;
    if (last.cnt !== 6'd32) begin errors++; $display("FAIL squash_count got %0d want 32", last.cnt); end
    if (last.t !== {6'd35, 6'd34, 6'd33}) begin errors++; $display("FAIL squash_tags got %h want 23 22 21", last.t); end
    repeat (9) step(1, 3'b111, 3'b000, '0, 0);
    step(1, 3'b111, 3'b000, '0, 0);
    checks += 2;
    if (last.v !== 3'b011) begin errors++; $display("FAIL squash_tail_valid got %b want 011", last.v); end
    if (last.t[1] !== 6'd3) begin errors++; $display("FAIL squash_32nd got %0d want 3", last.t[1]); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks += 4;
      if (o.v !== e.v) begin errors++; $display("FAIL squash sb_valid got %b want %b", o.v, e.v); end
      if (o.t !== e.t) begin errors++; $display("FAIL squash sb_tags got %h want %h", o.t, e.t); end
      if (o.cnt !== e.cnt) begin errors++; $display("FAIL squash sb_count got %0d want %0d", o.cnt, e.cnt); end
      if (o.ovf !== e.ovf) begin errors++; $display("FAIL squash sb_ovf got %b want %b", o.ovf, e.ovf); end
    end
  endtask

  task automatic test_overflow();
    snap_t e, o;
    do_reset();
    step(1, 3'b000, 3'b001, {6'd0, 6'd0, 6'd9}, 0);
    step(1, 3'b000, 3'b000, '0, 0);
    checks += 2;
    if (last.ovf !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %b want 1", last.ovf); end
    if (last.cnt !== 6'd32) begin errors++; $display("FAIL ovf_count got %0d want 32", last.cnt); end
    step(0, 3'b111, 3'b111, {6'd3, 6'd2, 6'd1}, 0);
    checks++;
    if (last.ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", last.ovf); end
    step(1, 3'b111, 3'b000, '0, 0);
    checks += 3;
    if (last.cnt !== 6'd32) begin errors++; $display("FAIL midreset_count got %0d want 32", last.cnt); end
    if (last.t !== {6'd34, 6'd33, 6'd32}) begin errors++; $display("FAIL midreset_tags got %h want 22 21 20", last.t); end
    if (last.ovf !== 1'b0) begin errors++; $display("FAIL midreset_ovf got %b want 0", last.ovf); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks += 4;
      if (o.v !== e.v) begin errors++; $display("FAIL ovf sb_valid got %b want %b", o.v, e.v); end
      if (o.t !== e.t) begin errors++; $display("FAIL ovf sb_tags got %h want %h", o.t, e.t); end
      if (o.cnt !== e.cnt) begin errors++; $display("FAIL ovf sb_count got %0d want %0d", o.cnt, e.cnt); end
      if (o.ovf !== e.ovf) begin errors++; $display("FAIL ovf sb_ovf got %b want %b", o.ovf, e.ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_sparse();
    test_free_empty();
    test_wrap();
    test_squash();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/freelist.md
# freelist

Physical-register free list for the 3-way R10K-style out-of-order core. It sits beside the ROB: it supplies new destination tags (`t_idx`) to dispatch and takes back the `told_idx` of retiring instructions. It is a circular buffer of free physical-register indices with a head (allocate) pointer and a tail (free) pointer. Retire-time squash recovery is a single-cycle pointer restore.

## Interface
- `SUPERSCALAR_WAYS`, default 3: dispatch/retire width. Way 0 is the oldest.
- `PHYS_REGS`, default 64: number of physical registers. `PR_W = $clog2(PHYS_REGS)` (6).
- `ARCH_REGS`, default 32: number of architectural registers.
- Derived: `FL_SIZE = PHYS_REGS - ARCH_REGS` (32); `PTR_W = $clog2(FL_SIZE)` (5); `CNT_W = PTR_W+1` (6).
- Ports:
  - `clock`  in  1: single clock; all state updates on its rising edge.
  - `reset`  in  1: synchronous, active-low. State resets when `reset==0` at a rising edge.
  - `dispatch_req`  in  WAYS: per-way tag allocation request from dispatch.
  - `retire_free_valid`  in  WAYS: per-way retire; return `retire_told_idx[i]`.
  - `retire_told_idx`  in  WAYS×PR_W: old physical tag freed at retire.
  - `squash`  in  1: a mispredicted branch retires this cycle; roll back all in-flight allocations.
  - `free_t_idx`  out  WAYS×PR_W: tag offered to way i (combinational).
  - `free_valid`  out  WAYS: way i is granted `free_t_idx[i]` this cycle (combinational).
  - `free_count`  out  CNT_W: registered number of free entries.
  - `overflow_err`  out  1: registered one-cycle pulse when frees were dropped for exceeding capacity.

## Operation
- State:
  - `buf[FL_SIZE]` of PR_W entries.
  - `head`, `tail` (PTR_W bits, wrap modulo FL_SIZE).
  - `count` (CNT_W bits).
- Invariant: entries `buf[head .. head+count-1]` (mod FL_SIZE) are free. The remaining slots hold tags of in-flight (dispatched, unretired) instructions. `count + in-flight = FL_SIZE` at all times.
- Reset (`reset==0`):
  - `buf[i] = ARCH_REGS + i` (32..63).
  - `head = tail = 0`, `count = 32`, `overflow_err = 0`.
- Allocation (combinational):
  - Let `n_i` = popcount of `dispatch_req[0..i-1]`.
  - `free_t_idx[i] = buf[head + n_i]`.
  - `free_valid[i] = dispatch_req[i] & (n_i + 1 <= count) & !squash`.
  - Non-requesting ways get `free_valid = 0`, and `free_t_idx` still shows `buf[head + n_i]`.
  - Grants are therefore in order: if way i is denied, every higher requesting way is denied.
- Allocation update: `head += popcount(free_valid)`.
- Free:
  - Each `retire_free_valid[i]`, processed in way order, writes `retire_told_idx[i]` to `buf[tail + m_i]`, where `m_i` = popcount of `retire_free_valid[0..i-1]`.
  - Then `tail += popcount(retire_free_valid)`.
- Count update: `count_next = count - n_alloc + n_free`.
- Same-cycle frees are not bypassed to allocation. Availability uses the registered `count` only.
- Overflow:
  - Triggered if `count - n_alloc + n_free > FL_SIZE`.
  - Only the lowest-indexed frees that fit are written; the rest are dropped.
  - `count` saturates at FL_SIZE and `overflow_err` pulses for 1 cycle.
  - Indicates an upstream bug.
- Squash:
  - All `free_valid` are forced to 0, so there is no allocation.
  - Same-cycle frees are still written and `tail` advances.
  - Next state: `head = tail_next`, `count = FL_SIZE`. In-flight tags are still resident in the buffer, so they become free again with no copying.
- Reset has priority over squash, free and allocation in the same cycle.

## Timing
- `free_t_idx` and `free_valid` are combinational from `dispatch_req`, `squash` and registered state. There is no input-to-state bypass.
- An allocation takes effect at the next rising edge; the next tags appear the following cycle.
- A freed tag becomes allocatable in the cycle after the free.
- After reset, with `dispatch_req=111`: `free_t_idx` = 32, 33, 34; `free_valid = 111`; `free_count = 32`.
- Pointer wrap from 31 to 0 is seamless. Full (`count==32`) and empty (`count==0`) are distinguished by `count`, not by pointer compare (head==tail in both).

## Test plan
- **Reset:** `reset=0` for 1 cycle, then `reset=1`, `dispatch_req=000` → `free_count=32`; with `dispatch_req=111`, `free_t_idx=32,33,34` and `free_valid=111`.
- **Sparse request and exhaustion:**
  - `dispatch_req=101` → way 0 gets 32, way 2 gets 33, `free_valid=101`.
  - Then `dispatch_req=111` for 9 cycles → `count=3`. Next cycle allocates 61, 62, 63 → `count=0`, then `free_valid=000`.
  - With `count=2`, `dispatch_req=111` → `free_valid=011`.
- **Free at empty:** `count=0`, retire frees tags 5 and 6 with `dispatch_req=001` → `free_valid=000` that cycle. Next cycle `free_t_idx[0]=5`, `free_valid[0]=1`, `free_count=2`.
- **Wrap:**
  - Allocate all 32 tags.
  - Free 40..71 mod 64 over 11 cycles, 3 per cycle (last cycle 2).
  - Re-allocate → tags come back in exactly the freed order across the 31→0 wrap.
- **Squash:**
  - After reset, allocate 6 tags (32..37).
  - Then `squash=1`, free `told=3` on way 0 with `dispatch_req=111` → `free_valid=000`. Next cycle `free_count=32` and `free_t_idx=33,34,35`.
  - Tag 3 is offered as the 32nd allocation.
- **Reset mid-operation and overflow:**
  - With `count=32`, free one tag → `overflow_err=1` for 1 cycle, `count` stays 32.
  - Then `reset=0` with `dispatch_req=111` and frees active → next cycle `free_count=32`, `free_t_idx=32,33,34`, `overflow_err=0`.
